tdes_decrypt_core: RTL and testbench

Iterative two-key Triple-DES decryption engine: plaintext = D_k1(E_k2(D_k1(ciphertext))). It is the inverse of the team's EDE encrypt path. It executes one DES round per clock, for 48 rounds in total. Sits behind the encrypt top as the recovery path. Valid/ready handshake on both sides; one block in flight.

---
 rtl/tdes_pkg.sv | 153 +++++++++++++++
 rtl/tdes_decrypt_core_if.sv | 27 ++
 rtl/tdes_round.sv | 30 +++
 rtl/tdes_decrypt_core.sv | 143 ++++++++++++++
 tb/tb_tdes_decrypt_core.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdes_pkg
// Description : DES permutation/S-box tables, key rotation schedules, FSM
//               state type and bit-level permutation helpers.
// Revision    : 1.0
// ============================================================================
package tdes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [47:0] subkey_t;

    // Tables use the standard 1-based, MSB-first bit numbering.
    localparam int C_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int C_FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int C_E [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int C_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int C_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Row-major: entry index = {row(b5,b0), col(b4..b1)}.
    localparam int C_SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    // Encrypt: left shift before round n. Decrypt: right shift before round n
    // (round 0 uses the key as loaded).
    localparam int C_ENC_ROT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int C_DEC_ROT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - C_IP[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - C_FP[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - C_E[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - C_P[5'(i)])];
        return y;
    endfunction

    function automatic subkey_t pc2_perm(input logic [55:0] x);
        subkey_t y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - C_PC2[6'(i)])];
        return y;
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] b, input logic [5:0] x);
        return 4'(C_SBOX[b][{x[5], x[0], x[4:1]}]);
    endfunction

    function automatic logic [55:0] cd_rotl(input logic [55:0] cd, input logic [1:0] n);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        case (n)
            2'd1:    begin c = {c[26:0], c[27]};    d = {d[26:0], d[27]};    end
            2'd2:    begin c = {c[25:0], c[27:26]}; d = {d[25:0], d[27:26]}; end
            default: ;
        endcase
        return {c, d};
    endfunction

    function automatic logic [55:0] cd_rotr(input logic [55:0] cd, input logic [1:0] n);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        case (n)
            2'd1:    begin c = {c[0], c[27:1]};   d = {d[0], d[27:1]};   end
            2'd2:    begin c = {c[1:0], c[27:2]}; d = {d[1:0], d[27:2]}; end
            default: ;
        endcase
        return {c, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdes_decrypt_core_if.sv
`default_nettype none
// ============================================================================
// Module      : tdes_decrypt_core_if
// Description : Ciphertext-in / plaintext-out valid/ready bundle.
// Revision    : 1.0
// ============================================================================
interface tdes_decrypt_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] key1;
    logic [55:0] key2;
    logic [63:0] ciphertext;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;

    modport master (
        output in_valid, key1, key2, ciphertext, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, key1, key2, ciphertext, out_ready,
        output in_ready, out_valid, plaintext
    );
endinterface
`default_nettype wire

// File: rtl/tdes_round.sv
`default_nettype none
// ============================================================================
// Module      : tdes_round
// Description : Combinational DES Feistel round: {L,R} -> {R, L ^ f(R,K)}.
// Revision    : 1.0
// ============================================================================
module tdes_round
    import tdes_pkg::*;
(
    input  wire logic [31:0] i_l,
    input  wire logic [31:0] i_r,
    input  wire subkey_t     i_key,
    output logic      [31:0] o_l,
    output logic      [31:0] o_r
);
    logic [47:0] w_x;
    logic [31:0] w_s;

    always_comb begin
        w_x = e_expand(i_r) ^ i_key;
        w_s = '0;
        for (int b = 0; b < 8; b++) begin
            w_s = {w_s[27:0], sbox(3'(b), 6'(w_x >> (42 - 6 * b)))};
        end
    end

    assign o_l = i_r;
    assign o_r = i_l ^ p_perm(w_s);
endmodule
`default_nettype wire

// File: rtl/tdes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : tdes_decrypt_core
// Description : Iterative two-key 3DES (D-E-D) decrypt, one round per clock.
//               Optional macro TDES_ZEROIZE_EN clears secrets on handshake.
// Revision    : 1.0
// ============================================================================
module tdes_decrypt_core
    import tdes_pkg::*;
#(
    parameter int ROUNDS_PER_PASS = 16,
    parameter int NUM_PASSES      = 3
) (
    input wire logic           clk,
    input wire logic           rst,
    tdes_decrypt_core_if.slave bus
);
    localparam int C_TOTAL = ROUNDS_PER_PASS * NUM_PASSES;
    localparam int C_CNT_W = $clog2(C_TOTAL);
    localparam int C_RND_W = $clog2(ROUNDS_PER_PASS);
    localparam logic [C_CNT_W-1:0] C_LAST_RND = C_CNT_W'(C_TOTAL - 1);
    localparam logic [C_RND_W-1:0] C_PASS_END = C_RND_W'(ROUNDS_PER_PASS - 1);

    state_t                       r_state;
    state_t                       w_state_nx;
    logic                         w_in_ready;
    logic                         w_out_valid;
    logic                         w_accept;
    logic                         w_out_hs;
    logic [55:0]                  r_key1;
    logic [55:0]                  r_key2;
    logic [55:0]                  r_cd;
    logic [55:0]                  w_cd_rot;
    logic [31:0]                  r_l;
    logic [31:0]                  r_r;
    logic [31:0]                  w_l_nx;
    logic [31:0]                  w_r_nx;
    logic [C_CNT_W-1:0]           r_cnt;
    logic [C_RND_W-1:0]           w_rnd;
    logic [C_CNT_W-C_RND_W-1:0]   w_pass;
    logic [63:0]                  r_pt;
    subkey_t                      w_subkey;

    assign w_rnd  = r_cnt[C_RND_W-1:0];
    assign w_pass = r_cnt[C_CNT_W-1:C_RND_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nx = ROUND;
            end
            ROUND: begin
                if (r_cnt == C_LAST_RND) w_state_nx = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_out_hs = w_out_valid & bus.out_ready;

    // Pass 1 is an encrypt pass; passes 0 and 2 walk the schedule backwards.
    always_comb begin
        w_cd_rot = r_cd;
        if (w_pass == 2'd1) w_cd_rot = cd_rotl(r_cd, 2'(C_ENC_ROT[w_rnd]));
        else                w_cd_rot = cd_rotr(r_cd, 2'(C_DEC_ROT[w_rnd]));
    end

    assign w_subkey = pc2_perm(w_cd_rot);

    tdes_round u_round (
        .i_l   (r_l),
        .i_r   (r_r),
        .i_key (w_subkey),
        .o_l   (w_l_nx),
        .o_r   (w_r_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key1 <= '0;
            r_key2 <= '0;
            r_cd   <= '0;
            r_l    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_pt   <= '0;
        end else if (w_accept) begin
            r_key1     <= bus.key1;
            r_key2     <= bus.key2;
            r_cd       <= bus.key1;
            {r_l, r_r} <= ip_perm(bus.ciphertext);
            r_cnt      <= '0;
        end else if (r_state == ROUND) begin
            if (r_cnt == C_LAST_RND) begin
                r_pt  <= fp_perm({w_r_nx, w_l_nx});
                r_cnt <= '0;
            end else if (w_rnd == C_PASS_END) begin
                // Swap replaces the FP/IP pair that cancels between passes.
                r_l   <= w_r_nx;
                r_r   <= w_l_nx;
                r_cd  <= (w_pass == 2'd0) ? r_key2 : r_key1;
                r_cnt <= r_cnt + C_CNT_W'(1);
            end else begin
                r_l   <= w_l_nx;
                r_r   <= w_r_nx;
                r_cd  <= w_cd_rot;
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
        end
`ifdef TDES_ZEROIZE_EN
        else if (w_out_hs) begin
            r_key1 <= '0;
            r_key2 <= '0;
            r_cd   <= '0;
            r_l    <= '0;
            r_r    <= '0;
        end
`endif
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
`ifdef TDES_ZEROIZE_EN
    assign bus.plaintext = w_out_valid ? r_pt : 64'd0;
`else
    assign bus.plaintext = r_pt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_tdes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdes_decrypt_core
// Description : Directed self-checking bench for tdes_decrypt_core
//               (honours TDES_ZEROIZE_EN when defined).
// Revision    : 1.0
// ============================================================================
module tb_tdes_decrypt_core;
    import tdes_pkg::*;

    localparam logic [55:0] C_K_STD  = 56'hF0CCAAF556678F;
    localparam logic [63:0] C_CT_STD = 64'h85E813540F0AB405;
    localparam logic [63:0] C_PT_STD = 64'h0123456789ABCDEF;
    localparam logic [63:0] C_CT_ZK  = 64'h8CA64DE9C1B123A7;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n;
    int   stable;

    tdes_decrypt_core_if bus ();

    tdes_decrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Independent single-DES reference operating on PC-1 form keys.
    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] ex;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        ex = '0;
        p  = '0;
        for (int i = 0; i < 48; i++) ex[6'(47 - i)] = r[5'(32 - C_E[6'(i)])];
        ex = ex ^ k;
        s  = '0;
        for (int b = 0; b < 8; b++) begin
            six = 6'(ex >> (42 - 6 * b));
            s   = {s[27:0], 4'(C_SBOX[3'(b)][{six[5], six[0], six[4:1]}])};
        end
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - C_P[5'(i)])];
        return p;
    endfunction

    function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [55:0] key, input bit dec);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [63:0] x;
        logic [63:0] y;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        cd = key;
        x  = '0;
        y  = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < C_ENC_ROT[4'(i)]; j++)
                cd = {cd[54:28], cd[55], cd[26:0], cd[27]};
            ks[4'(i)] = '0;
            for (int j = 0; j < 48; j++) ks[4'(i)][6'(47 - j)] = cd[6'(56 - C_PC2[6'(j)])];
        end
        for (int i = 0; i < 64; i++) x[6'(63 - i)] = blk[6'(64 - C_IP[6'(i)])];
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ m_f(r, ks[4'(dec ? 15 - i : i)]);
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - C_FP[6'(i)])];
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [55:0] k1, input logic [55:0] k2, input logic [63:0] ct);
        bus.in_valid   = 1'b1;
        bus.key1       = k1;
        bus.key2       = k2;
        bus.ciphertext = ct;
        tick();
        bus.in_valid   = 1'b0;
        bus.key1       = ~k1;
        bus.key2       = ~k2;
        bus.ciphertext = ~ct;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        logic [63:0] pt;
        logic [63:0] ct;
        logic [55:0] k1;
        logic [55:0] k2;
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.key1       = '0;
        bus.key2       = '0;
        bus.ciphertext = '0;
        bus.out_ready  = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_plaintext", bus.plaintext, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Classic single-DES vector (key1 == key2 collapses D-E-D to D).
        send(C_K_STD, C_K_STD, C_CT_STD);
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        wait_done(n);
        chk("std_latency", 64'(n), 64'd48);
        chk("std_plaintext", bus.plaintext, C_PT_STD);
        chk("done_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("hs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("hs_in_ready", 64'(bus.in_ready), 64'd1);

        send(56'd0, 56'd0, C_CT_ZK);
        wait_done(n);
        chk("zk_latency", 64'(n), 64'd48);
        chk("zk_plaintext", bus.plaintext, 64'd0);
        tick();

        // Back-pressure with ignored input pulses.
        bus.out_ready = 1'b0;
        send(C_K_STD, C_K_STD, C_CT_STD);
        wait_done(n);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid   = i[0];
            bus.ciphertext = {$urandom, $urandom};
            tick();
            if (bus.plaintext === C_PT_STD && bus.in_ready === 1'b0 && bus.out_valid === 1'b1)
                stable++;
        end
        chk("bp_stable_cycles", 64'(stable), 64'd20);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef TDES_ZEROIZE_EN
        chk("zero_plaintext", bus.plaintext, 64'd0);
        chk("zero_key1", 64'(dut.r_key1), 64'd0);
        chk("zero_key2", 64'(dut.r_key2), 64'd0);
        chk("zero_lr", {dut.r_l, dut.r_r}, 64'd0);
`else
        chk("hold_plaintext", bus.plaintext, C_PT_STD);
`endif

        // Asynchronous reset in the middle of pass 1.
        send(C_K_STD, C_K_STD, C_CT_STD);
        repeat (20) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_plaintext", bus.plaintext, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        send(C_K_STD, C_K_STD, C_CT_STD);
        wait_done(n);
        chk("post_rst_latency", 64'(n), 64'd48);
        chk("post_rst_plaintext", bus.plaintext, C_PT_STD);
        tick();

        // Distinct keys against an EDE encryption of random blocks.
        for (int it = 0; it < 100; it++) begin
            pt = {$urandom, $urandom};
            k1 = 56'({$urandom, $urandom});
            k2 = 56'({$urandom, $urandom});
            if (k1 == k2) k2 = k2 ^ 56'd1;
            ct = m_des(m_des(m_des(pt, k1, 1'b0), k2, 1'b1), k1, 1'b0);
            send(k1, k2, ct);
            wait_done(n);
            chk($sformatf("rand%0d", it), bus.plaintext, pt);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
